// File: rtl/picocpu_bus_pkg.sv
// Shared types for the picoCPU memory bus arbiter.
package picocpu_bus_pkg;

  localparam int NUM_MST = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } mst_t;

endpackage

// File: rtl/arb_rr_pick2.sv
// Two-master round-robin picker with a lock override that lets M1
// keep the bus across a burst as long as it was the last owner.
module arb_rr_pick2
  import picocpu_bus_pkg::*;
(
  input  logic [NUM_MST-1:0] req,
  input  mst_t               last,
  input  logic               lock,
  output logic [NUM_MST-1:0] gnt,
  output logic               valid
);

  // One-hot pick: single requester wins outright, ties go to the
  // master that was not served last unless M1 holds the lock.
  always_comb begin
    gnt   = '0;
    valid = |req;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == M0 || lock) ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises CPU (M0) and loader (M1) accesses onto the single-port RAM.
// Each transaction: one arbitration cycle, one strobe cycle, MEM_LAT-1
// wait cycles, one acknowledge cycle.
module mem_bus_arbiter
  import picocpu_bus_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          M0_REQ,
  input  logic          M0_WE,
  input  logic [AW-1:0] M0_ADDR,
  input  logic [DW-1:0] M0_WDATA,
  output logic          M0_ACK,
  output logic [DW-1:0] M0_RDATA,
  input  logic          M1_REQ,
  input  logic          M1_WE,
  input  logic [AW-1:0] M1_ADDR,
  input  logic [DW-1:0] M1_WDATA,
  output logic          M1_ACK,
  output logic [DW-1:0] M1_RDATA,
  input  logic          M1_LOCK,
  output logic          MEM_CS,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic [1:0]    GNT,
  output logic          BUSY
);

  // state | meaning
  // IDLE  | arbitrate, latch winner's request
  // ISSUE | MEM_CS strobe for one cycle
  // WAIT  | RAM read latency beyond the first cycle
  // DONE  | ACK to owner, read data passed through

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  arb_state_t          state_q, state_d;
  logic [NUM_MST-1:0]  gnt_q, gnt_d;
  mst_t                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;

  logic [NUM_MST-1:0]  pick_gnt;
  logic                pick_valid;
  logic                ack0, ack1;

  arb_rr_pick2 u_pick (
    .req   ({M1_REQ, M0_REQ}),
    .last  (last_q),
    .lock  (M1_LOCK),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // State and request registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= M1;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state, grant capture and latency counter.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ISSUE;
          gnt_d   = pick_gnt;
          last_d  = pick_gnt[1] ? M1 : M0;
          we_d    = pick_gnt[1] ? M1_WE    : M0_WE;
          addr_d  = pick_gnt[1] ? M1_ADDR  : M0_ADDR;
          wdata_d = pick_gnt[1] ? M1_WDATA : M0_WDATA;
        end
      end
      ISSUE: begin
        if (MEM_LAT > 1) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus and master-side outputs decoded from the state and latched request.
  always_comb begin
    ack0      = (state_q == DONE) && gnt_q[0];
    ack1      = (state_q == DONE) && gnt_q[1];
    MEM_CS    = (state_q == ISSUE);
    MEM_WE    = (state_q == ISSUE) && we_q;
    MEM_ADDR  = addr_q;
    MEM_WDATA = wdata_q;
    M0_ACK    = ack0;
    M1_ACK    = ack1;
    M0_RDATA  = (ack0 && !we_q) ? MEM_RDATA : '0;
    M1_RDATA  = (ack1 && !we_q) ? MEM_RDATA : '0;
    GNT       = gnt_q;
    BUSY      = (state_q != IDLE);
  end

endmodule
